svr_load_gather: RTL and testbench
==================================

Name: svr_load_gather

Overview:
- Vector-load sequencer: writer side of the scalar/vector register file (SVR) write port.
- Accepts one load command (base address, destination register, VL), issues 1/4/16 word reads to the data memory, and collects in-order responses into a 512-bit buffer.
- Then performs a single-cycle multi-word register-file write (we/VL/wa/wd) in the SVR write-port format.

Parameters:
- NREG, 31, number of register-file entries (valid indices 0..NREG-1)
- AW, 32, memory address width

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  load command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_vl  in  2  00=1 elem, 01=4 elems, 10=16 elems, 11=reserved
- cmd_wa  in  5  destination register index of element 0
- cmd_base  in  AW  byte address of element 0
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  AW  request byte address
- mem_rsp_valid  in  1  read data valid, in request order
- mem_rsp_data  in  32  read data
- rf_we  out  1  register-file write strobe (one cycle)
- rf_vl  out  2  VL code for the write
- rf_wa  out  5  write base index
- rf_wd  out  512  element i in bits [32*i+:32]
- busy  out  1  command in flight
- err  out  1  one-cycle pulse: command rejected

Behaviour:
- Reset (rst=1 at posedge): state IDLE; cmd_ready=1; mem_req_valid=0; rf_we=0; rf_vl=0; rf_wa=0; rf_wd=0; busy=0; err=0; all counters and buffer cleared. Reset mid-command abandons it: no rf_we, and late responses are ignored.
- N = 1/4/16 for cmd_vl 00/01/10.
- States:
  - IDLE: cmd_ready=1. On accept:
    - If cmd_vl==11 or cmd_wa+N-1 > NREG-1: pulse err next cycle, stay IDLE, no memory traffic.
    - Else latch vl/wa/base, zero buffer, clear issue_cnt and rsp_cnt, go FETCH.
  - FETCH:
    - mem_req_valid=1 while issue_cnt<N; mem_req_addr = base + 4*issue_cnt.
    - Address and valid are held stable until mem_req_ready; issue_cnt increments on handshake.
    - Each mem_rsp_valid while rsp_cnt<issue_cnt writes the buffer lane rsp_cnt, then rsp_cnt increments.
    - A request handshake and a response in the same cycle are both honoured.
    - Responses with rsp_cnt==issue_cnt are ignored.
    - When rsp_cnt reaches N, go WRITE next cycle.
  - WRITE: rf_we=1 for exactly one cycle; rf_vl/rf_wa are the latched values; rf_wd is the buffer. Lanes >= N read as zero. Next state IDLE.
- Output timing:
  - cmd_ready=0 and busy=1 in FETCH and WRITE.
  - rf_vl/rf_wa/rf_wd hold their values after WRITE until the next write.
- Latency: with mem_req_ready tied 1 and 1-cycle memory, accept-to-rf_we = N+2 cycles.
- Address arithmetic: modulo 2^AW, wraps silently.
- Back-to-back: a new command can be accepted the cycle after rf_we.

Optional Feature:
- Macro: SVR_GATHER_STRIDE_EN.
- Defined: adds input cmd_stride (AW bits, signed byte stride, latched on accept); mem_req_addr = base + cmd_stride*issue_cnt (modulo 2^AW). Stride 0 is legal and replicates one word.
- Undefined: no cmd_stride port; stride is fixed at 4 bytes (unit-stride).

Test Plan:
- Reset then VL=00, wa=3, base=0x100, mem returns 0xDEADBEEF -> one request at 0x100; rf_we pulse with rf_vl=00, rf_wa=3, rf_wd[31:0]=0xDEADBEEF, rf_wd[511:32]=0; rf_we asserts 3 cycles after accept.
- VL=10, wa=8, base=0x200, mem_req_ready toggling 1,0,1,0 and data = address -> 16 requests 0x200..0x23C in order; rf_wd lane i = 0x200+4i; exactly one rf_we.
- VL=01, wa=28 (28+3=31 > 30) -> err pulse, no mem_req_valid, no rf_we; VL=11 with wa=0 -> same.
- rst asserted after 2 of 4 responses of a VL=01 command, then a VL=00 command to wa=0 -> no write for the aborted command; rf_wa=0 write from the new command only.
- Spurious mem_rsp_valid in IDLE and in FETCH with no outstanding request -> ignored; buffer unchanged.
- With SVR_GATHER_STRIDE_EN, VL=01, base=0x1000, stride=-8 -> addresses 0x1000, 0xFF8, 0xFF0, 0xFE8.

Source files
------------

// File: rtl/svr_load_gather_if.sv
// svr_load_gather_if: bundles the command, memory-read and register-file
// write buses of the vector-load sequencer.
//   master : sequencer view (drives cmd_ready, memory requests, rf write)
//   slave  : environment view (drives commands and memory responses)
// Optional macro SVR_GATHER_STRIDE_EN adds the cmd_stride command field.
interface svr_load_gather_if #(
  parameter int AW = 32
);
  // command channel
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_vl;
  logic [4:0]    cmd_wa;
  logic [AW-1:0] cmd_base;
`ifdef SVR_GATHER_STRIDE_EN
  logic [AW-1:0] cmd_stride;
`endif
  // memory read channel
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  // register-file write port
  logic          rf_we;
  logic [1:0]    rf_vl;
  logic [4:0]    rf_wa;
  logic [511:0]  rf_wd;
  // status
  logic          busy;
  logic          err;

  modport master (
`ifdef SVR_GATHER_STRIDE_EN
    input  cmd_stride,
`endif
    input  cmd_valid, cmd_vl, cmd_wa, cmd_base,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output cmd_ready, mem_req_valid, mem_req_addr,
    output rf_we, rf_vl, rf_wa, rf_wd, busy, err
  );

  modport slave (
`ifdef SVR_GATHER_STRIDE_EN
    output cmd_stride,
`endif
    output cmd_valid, cmd_vl, cmd_wa, cmd_base,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  cmd_ready, mem_req_valid, mem_req_addr,
    input  rf_we, rf_vl, rf_wa, rf_wd, busy, err
  );
endinterface

// File: rtl/svr_load_gather.sv
// svr_load_gather: vector-load sequencer feeding the SVR write port.
// Accepts one load command, issues 1/4/16 word reads, gathers the in-order
// responses into a 512-bit buffer and then performs one multi-word
// register-file write. All outputs are registered.
// Optional macro SVR_GATHER_STRIDE_EN: adds a signed byte stride latched
// with the command; without it the element stride is fixed at 4 bytes.
module svr_load_gather #(
  parameter int NREG = 31,
  parameter int AW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  svr_load_gather_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Element count for a VL code; the reserved code maps to zero elements.
  function automatic logic [4:0] vl_to_n(input logic [1:0] vl);
    logic [4:0] n;
    case (vl)
      2'b00:   n = 5'd1;
      2'b01:   n = 5'd4;
      2'b10:   n = 5'd16;
      default: n = 5'd0;
    endcase
    return n;
  endfunction

  // A command is refused for the reserved VL code or when its last element
  // would land past the final register-file entry. 7-bit math avoids wrap.
  function automatic logic cmd_rejected(input logic [1:0] vl, input logic [4:0] wa);
    logic [6:0] last_idx;
    logic       bad;
    last_idx = {2'b00, wa} + {2'b00, vl_to_n(vl)} - 7'd1;
    if (vl == 2'b11) begin
      bad = 1'b1;
    end else begin
      bad = (last_idx > 7'(NREG - 1));
    end
    return bad;
  endfunction

  state_t         state_r, state_s;
  logic [1:0]     vl_r, vl_s;
  logic [4:0]     wa_r, wa_s;
  logic [AW-1:0]  base_r, base_s;
`ifdef SVR_GATHER_STRIDE_EN
  logic [AW-1:0]  stride_r, stride_s;
`endif
  logic [4:0]     issue_cnt_r, issue_cnt_s;
  logic [4:0]     rsp_cnt_r, rsp_cnt_s;
  logic [511:0]   buf_r, buf_s;
  logic [4:0]     n_cur_s, n_next_s;
  logic [AW-1:0]  step_s;

  logic           cmd_ready_r, cmd_ready_s;
  logic           mem_req_valid_r, mem_req_valid_s;
  logic [AW-1:0]  mem_req_addr_r, mem_req_addr_s;
  logic           rf_we_r, rf_we_s;
  logic [1:0]     rf_vl_r, rf_vl_s;
  logic [4:0]     rf_wa_r, rf_wa_s;
  logic [511:0]   rf_wd_r, rf_wd_s;
  logic           busy_r, busy_s;
  logic           err_r, err_s;

  // Next-state and next-output computation; every register gets a hold default.
  always_comb begin
    state_s     = state_r;
    vl_s        = vl_r;
    wa_s        = wa_r;
    base_s      = base_r;
`ifdef SVR_GATHER_STRIDE_EN
    stride_s    = stride_r;
`endif
    issue_cnt_s = issue_cnt_r;
    rsp_cnt_s   = rsp_cnt_r;
    buf_s       = buf_r;
    rf_we_s     = 1'b0;
    rf_vl_s     = rf_vl_r;
    rf_wa_s     = rf_wa_r;
    rf_wd_s     = rf_wd_r;
    err_s       = 1'b0;
    n_cur_s     = vl_to_n(vl_r);

    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_r) begin
          if (cmd_rejected(bus.cmd_vl, bus.cmd_wa)) begin
            err_s = 1'b1;
          end else begin
            vl_s        = bus.cmd_vl;
            wa_s        = bus.cmd_wa;
            base_s      = bus.cmd_base;
`ifdef SVR_GATHER_STRIDE_EN
            stride_s    = bus.cmd_stride;
`endif
            issue_cnt_s = 5'd0;
            rsp_cnt_s   = 5'd0;
            buf_s       = {512{1'b0}};
            state_s     = ST_FETCH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_FETCH: begin
        if (rsp_cnt_r == n_cur_s) begin
          // all elements gathered: present the whole buffer in one write
          state_s = ST_WRITE;
          rf_we_s = 1'b1;
          rf_vl_s = vl_r;
          rf_wa_s = wa_r;
          rf_wd_s = buf_r;
        end else begin
          if (mem_req_valid_r && bus.mem_req_ready) begin
            issue_cnt_s = issue_cnt_r + 5'd1;
          end else begin
            issue_cnt_s = issue_cnt_r;
          end
          // only responses to requests already issued are accepted
          if (bus.mem_rsp_valid && (rsp_cnt_r < issue_cnt_r)) begin
            buf_s[{rsp_cnt_r[3:0], 5'd0} +: 32] = bus.mem_rsp_data;
            rsp_cnt_s = rsp_cnt_r + 5'd1;
          end else begin
            rsp_cnt_s = rsp_cnt_r;
          end
        end
      end

      ST_WRITE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // outputs are derived from the next state so they can be registered
    n_next_s    = vl_to_n(vl_s);
    cmd_ready_s = (state_s == ST_IDLE);
    busy_s      = (state_s != ST_IDLE);
`ifdef SVR_GATHER_STRIDE_EN
    step_s = stride_s * {{(AW-5){1'b0}}, issue_cnt_s};
`else
    step_s = {{(AW-7){1'b0}}, issue_cnt_s, 2'b00};
`endif
    if (state_s == ST_FETCH) begin
      mem_req_valid_s = (issue_cnt_s < n_next_s);
      mem_req_addr_s  = base_s + step_s;
    end else begin
      mem_req_valid_s = 1'b0;
      mem_req_addr_s  = mem_req_addr_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command context, counters, gather buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vl_r            <= 2'd0;
      wa_r            <= 5'd0;
      base_r          <= {AW{1'b0}};
`ifdef SVR_GATHER_STRIDE_EN
      stride_r        <= {AW{1'b0}};
`endif
      issue_cnt_r     <= 5'd0;
      rsp_cnt_r       <= 5'd0;
      buf_r           <= {512{1'b0}};
      cmd_ready_r     <= 1'b1;
      mem_req_valid_r <= 1'b0;
      mem_req_addr_r  <= {AW{1'b0}};
      rf_we_r         <= 1'b0;
      rf_vl_r         <= 2'd0;
      rf_wa_r         <= 5'd0;
      rf_wd_r         <= {512{1'b0}};
      busy_r          <= 1'b0;
      err_r           <= 1'b0;
    end else begin
      vl_r            <= vl_s;
      wa_r            <= wa_s;
      base_r          <= base_s;
`ifdef SVR_GATHER_STRIDE_EN
      stride_r        <= stride_s;
`endif
      issue_cnt_r     <= issue_cnt_s;
      rsp_cnt_r       <= rsp_cnt_s;
      buf_r           <= buf_s;
      cmd_ready_r     <= cmd_ready_s;
      mem_req_valid_r <= mem_req_valid_s;
      mem_req_addr_r  <= mem_req_addr_s;
      rf_we_r         <= rf_we_s;
      rf_vl_r         <= rf_vl_s;
      rf_wa_r         <= rf_wa_s;
      rf_wd_r         <= rf_wd_s;
      busy_r          <= busy_s;
      err_r           <= err_s;
    end
  end

  assign bus.cmd_ready     = cmd_ready_r;
  assign bus.mem_req_valid = mem_req_valid_r;
  assign bus.mem_req_addr  = mem_req_addr_r;
  assign bus.rf_we         = rf_we_r;
  assign bus.rf_vl         = rf_vl_r;
  assign bus.rf_wa         = rf_wa_r;
  assign bus.rf_wd         = rf_wd_r;
  assign bus.busy          = busy_r;
  assign bus.err           = err_r;

endmodule

// File: tb/tb_svr_load_gather.sv
// tb_svr_load_gather: directed self-checking bench for svr_load_gather.
// A small memory model answers each accepted request one cycle later.
`timescale 1ns/1ps
module tb_svr_load_gather;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  svr_load_gather_if #(.AW(AW)) bus();
  svr_load_gather #(.NREG(31), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // memory-model controls (written by tests only)
  int          ready_mode = 0;   // 0 ready tied high, 1 toggling, 2 held low
  int          data_mode  = 0;   // 0 constant data, 1 data = address
  logic [31:0] data_const = 32'h0;
  int          spur_cnt   = 0;
  logic [31:0] spur_data  = 32'h0;
  logic [AW-1:0] cur_stride = 32'd4;

  // model/monitor state (written by the negedge process only)
  int          spur_done  = 0;
  logic        hs_prev    = 1'b0;
  logic [AW-1:0] addr_prev = '0;
  logic [AW-1:0] req_q[$];
  int          we_cnt = 0, err_cnt = 0, reqv_cnt = 0, rsp_cnt_tb = 0;
  logic [1:0]  last_vl;
  logic [4:0]  last_wa;
  logic [511:0] last_wd;
  longint      last_we_time;

  // Monitor outputs and play the memory, away from the active edge.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      we_cnt++; last_vl = bus.rf_vl; last_wa = bus.rf_wa; last_wd = bus.rf_wd;
      last_we_time = $time;
    end
    if (bus.err === 1'b1) err_cnt++;
    if (bus.mem_req_valid === 1'b1) reqv_cnt++;
    if (hs_prev) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = (data_mode == 1) ? addr_prev[31:0] : data_const;
      rsp_cnt_tb++;
    end else if (spur_cnt != spur_done) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = spur_data;
      spur_done++;
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = 32'h0;
    end
    case (ready_mode)
      1:       bus.mem_req_ready = (bus.mem_req_ready === 1'b1) ? 1'b0 : 1'b1;
      2:       bus.mem_req_ready = 1'b0;
      default: bus.mem_req_ready = 1'b1;
    endcase
    hs_prev   = (bus.mem_req_valid === 1'b1) && bus.mem_req_ready;
    addr_prev = bus.mem_req_addr;
    if (hs_prev) req_q.push_back(bus.mem_req_addr);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Offer a command until accepted; returns the accepting edge time.
  task automatic issue(input logic [1:0] vl, input logic [4:0] wa,
                       input logic [AW-1:0] base, output longint acc_t);
    logic ok, was_ready;
    int budget;
    ok = 1'b0; budget = 0; acc_t = 0;
    bus.cmd_valid = 1'b1; bus.cmd_vl = vl; bus.cmd_wa = wa; bus.cmd_base = base;
`ifdef SVR_GATHER_STRIDE_EN
    bus.cmd_stride = cur_stride;
`endif
    while (!ok && budget < 50) begin
      was_ready = bus.cmd_ready;
      @(posedge clk);
      acc_t = $time;
      if (was_ready === 1'b1) ok = 1'b1;
      budget++;
      #2;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL accept: command never accepted (got %b want 1)", ok); end
  endtask

  task automatic wait_we(input int prev, input int budget);
    int n;
    n = 0;
    while (we_cnt <= prev && n < budget) begin tick(1); n++; end
    checks++;
    if (we_cnt <= prev) begin errors++; $display("FAIL we_timeout: rf_we count %0d want > %0d", we_cnt, prev); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); end
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", bus.mem_req_valid); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we: got %b want 0", bus.rf_we); end
    checks++; if (bus.rf_vl !== 2'd0) begin errors++; $display("FAIL rst_rf_vl: got %h want 0", bus.rf_vl); end
    checks++; if (bus.rf_wa !== 5'd0) begin errors++; $display("FAIL rst_rf_wa: got %h want 0", bus.rf_wa); end
    checks++; if (bus.rf_wd !== {512{1'b0}}) begin errors++; $display("FAIL rst_rf_wd: not zero"); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single;
    int w0, r0; longint acc;
    ready_mode = 0; data_mode = 0; data_const = 32'hDEADBEEF;
    w0 = we_cnt; r0 = req_q.size();
    issue(2'b00, 5'd3, 32'h100, acc);
    checks++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL single_busy: busy %b ready %b want 1 0", bus.busy, bus.cmd_ready); end
    wait_we(w0, 20);
    checks++; if (last_we_time - acc != 35) begin errors++; $display("FAIL single_latency: got %0d ns want 35", last_we_time - acc); end
    tick(3);
    checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL single_we_count: got %0d want 1", we_cnt - w0); end
    checks++; if (req_q.size() - r0 != 1) begin errors++; $display("FAIL single_req_count: got %0d want 1", req_q.size() - r0); end
    else begin
      checks++; if (req_q[r0] !== 32'h100) begin errors++; $display("FAIL single_req_addr: got %h want 100", req_q[r0]); end
    end
    checks++; if (last_vl !== 2'b00 || last_wa !== 5'd3) begin errors++; $display("FAIL single_vl_wa: got %h %h want 0 3", last_vl, last_wa); end
    checks++; if (last_wd[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_lane0: got %h want deadbeef", last_wd[31:0]); end
    checks++; if (last_wd[511:32] !== {480{1'b0}}) begin errors++; $display("FAIL single_upper: upper lanes not zero"); end
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_wa !== 5'd3 || bus.rf_wd[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold: we %b wa %h wd0 %h want 0 3 deadbeef", bus.rf_we, bus.rf_wa, bus.rf_wd[31:0]); end
  endtask

  task automatic test_vl16;
    int w0, r0, bad_req, bad_lane; longint acc;
    ready_mode = 1; data_mode = 1;
    w0 = we_cnt; r0 = req_q.size(); bad_req = 0; bad_lane = 0;
    issue(2'b10, 5'd8, 32'h200, acc);
    wait_we(w0, 200);
    tick(3);
    checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL vl16_we_count: got %0d want 1", we_cnt - w0); end
    checks++; if (req_q.size() - r0 != 16) begin errors++; $display("FAIL vl16_req_count: got %0d want 16", req_q.size() - r0); end
    else begin
      for (int i = 0; i < 16; i++) if (req_q[r0+i] !== 32'h200 + 32'(4*i)) bad_req++;
      checks++; if (bad_req != 0) begin errors++; $display("FAIL vl16_req_order: %0d wrong addresses want 0", bad_req); end
    end
    for (int i = 0; i < 16; i++) if (last_wd[32*i +: 32] !== 32'h200 + 32'(4*i)) bad_lane++;
    checks++; if (bad_lane != 0) begin errors++; $display("FAIL vl16_lanes: %0d wrong lanes want 0", bad_lane); end
    checks++; if (last_vl !== 2'b10 || last_wa !== 5'd8) begin errors++; $display("FAIL vl16_vl_wa: got %h %h want 2 8", last_vl, last_wa); end
    ready_mode = 0;
  endtask

  task automatic test_reject;
    logic [1:0] vls [3];
    logic [4:0] was [3];
    int w0, q0, e0; longint acc;
    vls[0] = 2'b01; was[0] = 5'd28;
    vls[1] = 2'b11; was[1] = 5'd0;
    vls[2] = 2'b10; was[2] = 5'd16;
    ready_mode = 0;
    for (int k = 0; k < 3; k++) begin
      w0 = we_cnt; q0 = reqv_cnt; e0 = err_cnt;
      issue(vls[k], was[k], 32'h700, acc);
      checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rej%0d_err: err %b busy %b want 1 0", k, bus.err, bus.busy); end
      tick(1);
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rej%0d_pulse: err %b want 0", k, bus.err); end
      tick(5);
      checks++; if (err_cnt - e0 != 1 || reqv_cnt != q0 || we_cnt != w0) begin errors++; $display("FAIL rej%0d_quiet: err %0d req %0d we %0d want 1 0 0", k, err_cnt - e0, reqv_cnt - q0, we_cnt - w0); end
    end
    // last legal placement: 27..30
    w0 = we_cnt; e0 = err_cnt; data_mode = 1;
    issue(2'b01, 5'd27, 32'h800, acc);
    wait_we(w0, 30);
    tick(2);
    checks++; if (we_cnt - w0 != 1 || err_cnt != e0 || last_wa !== 5'd27) begin errors++; $display("FAIL edge_wa27: we %0d err %0d wa %0d want 1 0 27", we_cnt - w0, err_cnt - e0, last_wa); end
  endtask

  task automatic test_reset_abort;
    int w0, s0, n; longint acc;
    ready_mode = 0; data_mode = 1;
    w0 = we_cnt; s0 = rsp_cnt_tb; n = 0;
    issue(2'b01, 5'd5, 32'h300, acc);
    while (rsp_cnt_tb - s0 < 2 && n < 20) begin tick(1); n++; end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++; if (bus.rf_we !== 1'b0 || bus.busy !== 1'b0 || bus.rf_wa !== 5'd0) begin errors++; $display("FAIL abort_reset: we %b busy %b wa %h want 0 0 0", bus.rf_we, bus.busy, bus.rf_wa); end
    issue(2'b00, 5'd0, 32'h400, acc);
    wait_we(w0, 20);
    tick(3);
    checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL abort_we_count: got %0d want 1", we_cnt - w0); end
    checks++; if (last_wa !== 5'd0 || last_wd[31:0] !== 32'h400 || last_wd[511:32] !== {480{1'b0}}) begin errors++; $display("FAIL abort_new_write: wa %h wd0 %h want 0 400", last_wa, last_wd[31:0]); end
  endtask

  task automatic test_spurious;
    logic [511:0] exp_wd;
    int w0, bad; longint acc;
    exp_wd = {512{1'b0}}; exp_wd[31:0] = 32'h400;
    spur_data = 32'hBAD0BAD0; spur_cnt++;
    tick(3);
    checks++; if (bus.rf_wd !== exp_wd || bus.rf_we !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL spur_idle: wd0 %h we %b busy %b want 400 0 0", bus.rf_wd[31:0], bus.rf_we, bus.busy); end
    ready_mode = 2; data_mode = 1; w0 = we_cnt; bad = 0;
    issue(2'b01, 5'd10, 32'h500, acc);
    spur_cnt++;
    tick(3);
    ready_mode = 0;
    wait_we(w0, 30);
    tick(2);
    for (int i = 0; i < 16; i++)
      if (last_wd[32*i +: 32] !== ((i < 4) ? 32'h500 + 32'(4*i) : 32'h0)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL spur_fetch_lanes: %0d wrong lanes want 0", bad); end
    checks++; if (we_cnt - w0 != 1 || last_wa !== 5'd10) begin errors++; $display("FAIL spur_fetch_we: we %0d wa %0d want 1 10", we_cnt - w0, last_wa); end
  endtask

  task automatic test_back_to_back;
    int w0, n; longint acc, we_edge;
    ready_mode = 0; data_mode = 1; w0 = we_cnt; n = 0; we_edge = 0;
    issue(2'b00, 5'd1, 32'h600, acc);
    while (bus.rf_we !== 1'b1 && n < 20) begin tick(1); n++; end
    we_edge = $time - 2;
    issue(2'b00, 5'd2, 32'h604, acc);
    checks++; if (acc - we_edge != 20) begin errors++; $display("FAIL b2b_accept: accepted %0d ns after rf_we edge want 20", acc - we_edge); end
    wait_we(w0 + 1, 20);
    tick(2);
    checks++; if (we_cnt - w0 != 2 || last_wa !== 5'd2 || last_wd[31:0] !== 32'h604) begin errors++; $display("FAIL b2b_second: we %0d wa %0d wd0 %h want 2 2 604", we_cnt - w0, last_wa, last_wd[31:0]); end
  endtask

`ifdef SVR_GATHER_STRIDE_EN
  task automatic test_stride;
    logic [31:0] exp_a [4];
    int w0, r0, bad; longint acc;
    exp_a[0] = 32'h1000; exp_a[1] = 32'h0FF8; exp_a[2] = 32'h0FF0; exp_a[3] = 32'h0FE8;
    ready_mode = 0; data_mode = 1; cur_stride = 32'hFFFF_FFF8;
    w0 = we_cnt; r0 = req_q.size(); bad = 0;
    issue(2'b01, 5'd0, 32'h1000, acc);
    wait_we(w0, 30);
    tick(2);
    checks++; if (req_q.size() - r0 != 4) begin errors++; $display("FAIL stride_req_count: got %0d want 4", req_q.size() - r0); end
    else begin
      for (int i = 0; i < 4; i++) if (req_q[r0+i] !== exp_a[i] || last_wd[32*i +: 32] !== exp_a[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL stride_addrs: %0d wrong elements want 0", bad); end
    end
    cur_stride = 32'd4;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_vl = 2'b00; bus.cmd_wa = 5'd0; bus.cmd_base = 32'h0;
`ifdef SVR_GATHER_STRIDE_EN
    bus.cmd_stride = 32'd4;
`endif
    @(posedge clk); #2;
    test_reset();
    test_single();
    test_vl16();
    test_reject();
    test_reset_abort();
    test_spurious();
    test_back_to_back();
`ifdef SVR_GATHER_STRIDE_EN
    test_stride();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
